// File: rtl/pe_stream_pkg.sv
// Shared definitions for the tagged IFMap stream: tag codes, tag bit
// positions and the writer FSM state encoding.
package pe_stream_pkg;

   localparam logic [1:0] TAG_SOR    = 2'b10;
   localparam logic [1:0] TAG_EOR    = 2'b01;
   localparam logic [1:0] TAG_MID    = 2'b00;
   localparam logic [1:0] TAG_SINGLE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_LOAD = 3'd2,
      ST_PUSH = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic int sor_bit(int data_width);
      return data_width + 1;
   endfunction

   function automatic int eor_bit(int data_width);
      return data_width;
   endfunction

   // A one-word row is both first and last column, hence TAG_SINGLE.
   function automatic logic [1:0] word_tag(logic first_col, logic last_col);
      logic [1:0] tag;
      if (first_col && last_col)
         tag = TAG_SINGLE;
      else if (first_col)
         tag = TAG_SOR;
      else if (last_col)
         tag = TAG_EOR;
      else
         tag = TAG_MID;
      return tag;
   endfunction

endpackage

// File: rtl/ifmap_stream_writer_if.sv
// Scratch RAM read port and circular-buffer write port seen by the writer.
interface ifmap_stream_writer_if #(
   parameter int DATA_WIDTH = 20,
   parameter int ADDR_WIDTH = 8
);
   logic                    mem_ren;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    buf_ready;
   logic                    buf_wen;
   logic [DATA_WIDTH+1:0]   buf_din;

   modport master (
      output mem_ren, mem_addr, buf_wen, buf_din,
      input  mem_rdata, buf_ready
   );

   modport slave (
      input  mem_ren, mem_addr, buf_wen, buf_din,
      output mem_rdata, buf_ready
   );
endinterface

// File: rtl/row_col_counter.sv
// Column/row position of the word currently held by the writer, with
// first-column, last-column and last-word flags.
module row_col_counter #(
   parameter int LEN_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   input  logic [LEN_WIDTH-1:0] row_len,
   input  logic [LEN_WIDTH-1:0] row_count,
   output logic                 first_col,
   output logic                 last_col,
   output logic                 last_word
);
   logic [LEN_WIDTH-1:0] col_reg;
   logic [LEN_WIDTH-1:0] row_reg;

   assign first_col = (col_reg == '0);
   assign last_col  = (col_reg == row_len - LEN_WIDTH'(1));
   assign last_word = last_col && (row_reg == row_count - LEN_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (advance) begin
         if (last_col) begin
            col_reg <= '0;
            row_reg <= row_reg + LEN_WIDTH'(1);
         end else begin
            col_reg <= col_reg + LEN_WIDTH'(1);
         end
      end
   end
endmodule

// File: rtl/ifmap_stream_writer.sv
// Streams row_count x row_len words from the scratch RAM into the IFMap
// circular buffer, tagging start/end of each row in the two MSBs.
module ifmap_stream_writer
   import pe_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  row_len,
   input  logic [LEN_WIDTH-1:0]  row_count,
   ifmap_stream_writer_if.master bus,
   output logic                  busy,
   output logic                  done
);
   localparam int SOR_POS = sor_bit(DATA_WIDTH);
   localparam int EOR_POS = eor_bit(DATA_WIDTH);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] base_reg, offset_reg, next_addr;
   logic [LEN_WIDTH-1:0]  len_reg, count_reg;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic [1:0]            tag_reg;
   logic                  clear, advance, first_col, last_col, last_word;
   logic                  mem_ren, buf_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH+1:0] buf_din;

   row_col_counter #(.LEN_WIDTH(LEN_WIDTH)) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .advance   (advance),
      .row_len   (len_reg),
      .row_count (count_reg),
      .first_col (first_col),
      .last_col  (last_col),
      .last_word (last_word)
   );

   assign next_addr = base_reg + offset_reg + ADDR_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      mem_ren    = 1'b0;
      mem_addr   = '0;
      buf_wen    = 1'b0;
      advance    = 1'b0;
      clear      = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = (row_len == '0 || row_count == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            mem_ren    = 1'b1;
            mem_addr   = base_reg;
            state_next = ST_LOAD;
         end
         ST_LOAD: state_next = ST_PUSH;
         ST_PUSH: begin
            // The next RAM read overlaps the accepted write, giving 2 cycles/word.
            if (bus.buf_ready) begin
               buf_wen = 1'b1;
               advance = 1'b1;
               if (last_word) begin
                  state_next = ST_DONE;
               end else begin
                  mem_ren    = 1'b1;
                  mem_addr   = next_addr;
                  state_next = ST_LOAD;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_reg   <= '0;
         offset_reg <= '0;
         len_reg    <= '0;
         count_reg  <= '0;
         hold_reg   <= '0;
         tag_reg    <= TAG_MID;
      end else begin
         if (state_reg == ST_IDLE && start) begin
            base_reg   <= base_addr;
            offset_reg <= '0;
            len_reg    <= row_len;
            count_reg  <= row_count;
         end
         if (state_reg == ST_LOAD) begin
            hold_reg <= bus.mem_rdata;
            tag_reg  <= word_tag(first_col, last_col);
         end
         if (state_reg == ST_PUSH && bus.buf_ready && !last_word)
            offset_reg <= offset_reg + ADDR_WIDTH'(1);
      end
   end

   always_comb begin
      buf_din                   = '0;
      buf_din[DATA_WIDTH-1:0]   = hold_reg;
      buf_din[SOR_POS]          = tag_reg[1];
      buf_din[EOR_POS]          = tag_reg[0];
   end

   assign busy = (state_reg == ST_READ) || (state_reg == ST_LOAD) || (state_reg == ST_PUSH);
   assign done = (state_reg == ST_DONE);

   assign bus.mem_ren  = mem_ren;
   assign bus.mem_addr = mem_addr;
   assign bus.buf_wen  = buf_wen;
   assign bus.buf_din  = buf_din;
endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Randomised scoreboard bench for ifmap_stream_writer with a behavioural
// model of word order, tags, addresses and cycle timing.
module tb_ifmap_stream_writer;
   localparam int DW  = 20;
   localparam int AW  = 8;
   localparam int LW  = 5;
   localparam int PAT = 600;

   typedef struct {
      int              cyc;
      logic [DW+1:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] row_len = '0;
   logic [LW-1:0] row_count = '0;
   logic          busy;
   logic          done;

   ifmap_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ifmap_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .row_len   (row_len),
      .row_count (row_count),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [256];
   int  cyc = 0;
   bit  ready_pat [PAT];
   int  start_cyc = -100000;
   int  ready_rel;
   int  mon_rel;
   exp_t addr_q[$];
   exp_t wen_q[$];
   exp_t stall_q[$];
   int  test_id = 0;
   int  done_seen_id = 0;
   int  exp_done_rel = 0;
   int  exp_n = 0;
   int  idle_chk_cyc = 2;
   int  words_seen = 0;
   bit  done_armed = 1'b0;
   int  chk_cnt = 0;
   int  fail_cnt = 0;

   // Synchronous-read scratch RAM
   always @(posedge clk)
      if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr];

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #2;
      ready_rel = cyc - start_cyc;
      bus.buf_ready = (ready_rel >= 0 && ready_rel < PAT) ? ready_pat[ready_rel] : 1'b1;
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      chk_cnt++;
      if (got !== want) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      mon_rel = cyc - start_cyc;
      if (cyc == idle_chk_cyc) begin
         check("idle_mem_ren", 32'(bus.mem_ren), 0);
         check("idle_mem_addr", 32'(bus.mem_addr), 0);
         check("idle_buf_wen", 32'(bus.buf_wen), 0);
         check("idle_buf_din", 32'(bus.buf_din), 0);
         check("idle_busy", 32'(busy), 0);
         check("idle_done", 32'(done), 0);
      end
      if (bus.mem_ren) begin
         if (addr_q.size() == 0) begin
            check("mem_ren_unexpected", 32'(bus.mem_ren), 0);
         end else begin
            e = addr_q.pop_front();
            check("mem_addr", 32'(bus.mem_addr), 32'(e.data));
            check("mem_ren_cycle", 32'(mon_rel), 32'(e.cyc));
         end
      end
      if (stall_q.size() > 0 && stall_q[0].cyc == mon_rel) begin
         e = stall_q.pop_front();
         check("stall_buf_wen", 32'(bus.buf_wen), 0);
         check("stall_buf_din", 32'(bus.buf_din), 32'(e.data));
      end
      if (bus.buf_wen) begin
         words_seen++;
         if (wen_q.size() == 0) begin
            check("buf_wen_unexpected", 32'(bus.buf_wen), 0);
         end else begin
            e = wen_q.pop_front();
            check("buf_din", 32'(bus.buf_din), 32'(e.data));
            check("buf_wen_cycle", 32'(mon_rel), 32'(e.cyc));
         end
      end
      if (done_armed && mon_rel == 1 && exp_n > 0)
         check("busy_read", 32'(busy), 1);
      if (done) begin
         if (!done_armed) begin
            check("done_unexpected", 32'(done), 0);
         end else begin
            check("done_cycle", 32'(mon_rel), 32'(exp_done_rel));
            check("busy_in_done", 32'(busy), 0);
            check("words_left", 32'(wen_q.size()), 0);
            done_seen_id = test_id;
         end
      end
      if (done_armed && done_seen_id != test_id && mon_rel == exp_done_rel + 20)
         check("done_timeout", 32'(done_seen_id), 32'(test_id));
   end

   task automatic set_ready(int mode);
      for (int i = 0; i < PAT; i++)
         ready_pat[i] = (mode == 2) ? ($urandom_range(0, 3) != 0) : !(mode == 1 && i >= 9 && i <= 13);
   endtask

   // Reference: word k of the transfer sits at base+k, column k%len; one
   // RAM read then a push two cycles later, each low ready cycle delaying it.
   task automatic build_model(int base, int len, int cnt);
      int t = 3;
      int rd = 1;
      int n = len * cnt;
      int a, c;
      exp_t e, ea, es;
      exp_n = n;
      if (n == 0) begin
         exp_done_rel = 1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         a = (base + k) % 256;
         c = k % len;
         e.data = {(c == 0), (c == len - 1), ram[a]};
         ea.cyc = rd;
         ea.data = (DW+2)'(a);
         addr_q.push_back(ea);
         while (t < PAT && !ready_pat[t]) begin
            es.cyc = t;
            es.data = e.data;
            stall_q.push_back(es);
            t++;
         end
         e.cyc = t;
         wen_q.push_back(e);
         rd = t;
         t += 2;
      end
      exp_done_rel = t - 1;
   endtask

   task automatic launch(int base, int len, int cnt);
      @(posedge clk);
      #1;
      test_id++;
      build_model(base, len, cnt);
      done_armed = 1'b1;
      base_addr = AW'(base);
      row_len = LW'(len);
      row_count = LW'(cnt);
      start = 1'b1;
      start_cyc = cyc;
   endtask

   task automatic wait_done(bit noise);
      for (int i = 0; i < PAT + 50; i++) begin
         @(posedge clk);
         #1;
         if (done_seen_id == test_id) break;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            base_addr = AW'($urandom);
            row_len = LW'($urandom);
            row_count = LW'($urandom);
         end else begin
            start = 1'b0;
         end
         if (cyc - start_cyc > exp_done_rel + 25) break;
      end
      start = 1'b0;
   endtask

   initial begin
      int vals [10] = '{19, -16, 17, -65, 34, -32, 13, -34, 21, -5};
      int w0;
      for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
      for (int i = 0; i < 10; i++) ram[16 + i] = DW'(vals[i]);
      set_ready(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      launch(16, 10, 1);  wait_done(0);
      launch(40, 3, 2);   wait_done(0);
      launch(60, 1, 3);   wait_done(0);
      launch(70, 0, 3);   wait_done(0);
      launch(70, 5, 0);   wait_done(0);
      set_ready(1);
      launch(16, 10, 1);  wait_done(0);
      set_ready(0);
      launch(254, 4, 1);  wait_done(0);

      for (int r = 0; r < 8; r++) begin
         set_ready(2);
         launch(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
         wait_done(1);
      end

      set_ready(0);
      w0 = words_seen;
      launch(100, 4, 2);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (words_seen >= w0 + 2) break;
      end
      done_armed = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      addr_q.delete();
      wen_q.delete();
      stall_q.delete();
      idle_chk_cyc = cyc;
      repeat (10) @(posedge clk);
      launch(100, 4, 2);  wait_done(0);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
      $finish;
   end
endmodule

// File: doc/ifmap_stream_writer.md
# ifmap_stream_writer

Producer side of the tagged IFMap stream consumed by the processing element. On `start`, reads `row_count` rows of `row_len` contiguous words from a synchronous-read scratch RAM and pushes them into the IFMap circular buffer as `DATA_WIDTH+2`-bit words, tagging start-of-row and end-of-row in the two MSBs. It replaces bench-driven buffer writes and sits between the IFMap scratch memory and the IFMap `circular_buffer` write port.

## Interface
- `DATA_WIDTH`, 20, payload width
- `ADDR_WIDTH`, 8, scratch RAM address width
- `LEN_WIDTH`, 5, width of `row_len` and `row_count`

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin transfer; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  address of first word; latched on accepted start
- `row_len`  in  LEN_WIDTH  words per row; latched on accepted start
- `row_count`  in  LEN_WIDTH  number of rows; latched on accepted start
- `mem_ren`  out  1  RAM read enable
- `mem_addr`  out  ADDR_WIDTH  RAM read address
- `mem_rdata`  in  DATA_WIDTH  RAM data, valid the cycle after `mem_ren`
- `buf_ready`  in  1  buffer not full
- `buf_wen`  out  1  buffer write enable; a word transfers in every cycle it is high
- `buf_din`  out  DATA_WIDTH+2  {SOR, EOR, payload}
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, LOAD, PUSH, DONE.
- IDLE: `start`=1 latches inputs and clears the column/row counters and address offset.
  - Either length zero: go to DONE with no RAM reads or buffer writes.
  - Otherwise go to READ.
- READ: `mem_ren`=1, `mem_addr`=`base_addr`; go to LOAD.
- LOAD: capture `mem_rdata` into the hold register and compute the tag; go to PUSH.
- PUSH: `buf_din` = {tag, hold}; `buf_wen` = `buf_ready`, combinational.
  - `buf_ready`=0: stay in PUSH; `buf_din` stable; no RAM read.
  - Transfer, words remaining: in the same cycle assert `mem_ren` with the next address; go to LOAD.
  - Transfer of the last word: go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- Tag per word:
  - `2'b10` on column 0.
  - `2'b01` on column `row_len`-1.
  - `2'b00` otherwise.
  - `2'b11` when `row_len`=1.
- Addressing:
  - Address = `base_addr` + linear word index, mod 2^ADDR_WIDTH; wrap-around is silent.
  - Rows are contiguous in memory.
- Counters:
  - Column counter wraps to 0 at `row_len`-1 and increments the row counter.
  - Completion = last column of row `row_count`-1 transferred.
- `start` while not IDLE is ignored. Input changes after latching have no effect.
- Payload passes through unmodified (no sign handling).
- `busy`=1 in READ, LOAD and PUSH; 0 in IDLE and DONE.

## Timing
- Reset values:
  - `mem_ren`, `buf_wen`, `busy`, `done` = 0.
  - `mem_addr` = 0; `buf_din` = 0.
  - State IDLE; counters and hold register 0.
- Reset mid-transfer:
  - Abort immediately; return to IDLE.
  - No `done` pulse.
  - Words already written stay in the buffer.
- Start accepted at cycle 0: READ at cycle 1, first possible `buf_wen` at cycle 3.
- Unstalled throughput is 1 word per 2 cycles.
  - N total words: last `buf_wen` at cycle 2N+1; `done` at cycle 2N+2; IDLE at cycle 2N+3.
- Zero length: `done` at cycle 1.
- Each cycle of `buf_ready`=0 in PUSH adds exactly one cycle.
- Words are never duplicated or dropped under any backpressure pattern.
- `buf_ready` may toggle every cycle.
- `start` asserted in the DONE cycle is ignored; the next start is accepted in IDLE.

## Structure
- Shared package `pe_stream_pkg`:
  - `TAG_SOR`=2'b10, `TAG_EOR`=2'b01, `TAG_MID`=2'b00, `TAG_SINGLE`=2'b11.
  - State encoding constants.
  - Tag bit positions: SOR = `DATA_WIDTH+1`, EOR = `DATA_WIDTH`.
- The processing element imports the same tag constants.
- One natural sub-module, `row_col_counter`: column and row counters with wrap and last-word flags.
- FSM, address adder and hold register remain in the top module.

## Test plan
- **Single row:** `row_len`=10, `row_count`=1, RAM = 19,-16,17,-65,34,-32,13,-34,21,-5, `buf_ready`=1.
  - `buf_din` sequence {10,19}, {00,-16} … {00,21}, {01,-5}.
  - First `buf_wen` at cycle 3; `done` at cycle 22.
- **Two rows:** `row_len`=3, `row_count`=2.
  - Tags 10,00,01,10,00,01.
  - Addresses `base`..`base`+5.
- **Single-column rows:** `row_len`=1, `row_count`=3.
  - Three words, all tagged 11.
  - `row_len`=0 → `done` at cycle 1; no `mem_ren` or `buf_wen`.
- **Backpressure:** hold `buf_ready`=0 for 5 cycles while the 4th word is in PUSH.
  - `buf_din` stable throughout; no `mem_ren`.
  - Output sequence identical to the unstalled run; completion 5 cycles later.
- **Address wrap:** `base_addr`=254, `row_len`=4, `ADDR_WIDTH`=8.
  - `mem_addr` 254, 255, 0, 1.
- **Reset mid-transfer:** `rst` after the 2nd word; then a new `start`.
  - Outputs zero the next cycle; no `done`.
  - The new transfer runs normally from `base_addr`.
